// File: rtl/sobel_window_ctrl_pkg.sv
// Shared types and defaults for the Sobel window controller and its line-buffer datapath.
package sobel_pkg;
  localparam int IMG_W_DEFAULT = 64;
  localparam int IMG_H_DEFAULT = 64;
  localparam int PIX_W         = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;
endpackage

// File: rtl/sobel_window_ctrl_if.sv
// Pixel-stream handshake plus status outputs of the Sobel window controller.
interface sobel_window_ctrl_if #(
  parameter int IMG_W = sobel_pkg::IMG_W_DEFAULT,
  parameter int IMG_H = sobel_pkg::IMG_H_DEFAULT
);
  import sobel_pkg::*;
  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);

  // A pixel transfers on a cycle where PixelValid and PixelReady are both high;
  // PixelValid never waits on PixelReady, and LineEnable marks exactly those cycles.
  logic             Start;
  logic             PixelValid;
  logic             PixelReady;
  logic             LineEnable;
  logic [COL_W-1:0] Col;
  logic [ROW_W-1:0] Row;
  logic             WindowValid;
  logic             FrameDone;
  logic             Busy;
  state_t           State;

  modport master (
    output Start, PixelValid,
    input  PixelReady, LineEnable, Col, Row, WindowValid, FrameDone, Busy, State
  );

  modport slave (
    input  Start, PixelValid,
    output PixelReady, LineEnable, Col, Row, WindowValid, FrameDone, Busy, State
  );
endinterface

// File: rtl/sobel_window_ctrl_pos.sv
// Raster position counter: column/row of the next pixel, wrapping at line and frame end.
module raster_pos_cnt #(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64,
  parameter int COL_W = $clog2(IMG_W),
  parameter int ROW_W = $clog2(IMG_H)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Clear,
  input  logic             Inc,
  output logic [COL_W-1:0] Col,
  output logic [ROW_W-1:0] Row,
  output logic             LastCol,
  output logic             LastPix
);
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;

  assign LastCol = (col_q == COL_W'(IMG_W - 1));
  assign LastPix = LastCol && (row_q == ROW_W'(IMG_H - 1));
  assign Col     = col_q;
  assign Row     = row_q;

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (Clear) begin
      col_d = '0;
      row_d = '0;
    end else if (Inc) begin
      if (LastCol) begin
        col_d = '0;
        row_d = LastPix ? '0 : row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end
endmodule

// File: rtl/sobel_window_ctrl.sv
// Sequences the line-buffer shift strobe and flags complete in-frame 3x3 windows.
module sobel_window_ctrl
  import sobel_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEFAULT,
  parameter int IMG_H = IMG_H_DEFAULT,
  parameter int COL_W = $clog2(IMG_W),
  parameter int ROW_W = $clog2(IMG_H)
) (
  input logic CLK,
  input logic RST,
  sobel_window_ctrl_if.slave bus
);
  state_t           state_q, state_d;
  logic             ready;
  logic             accept;
  logic             clear;
  logic             wv_q, wv_d;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic             last_col;
  logic             last_pix;

  assign ready  = (state_q == FILL) || (state_q == RUN);
  assign accept = bus.PixelValid && ready;

  raster_pos_cnt #(
    .IMG_W(IMG_W),
    .IMG_H(IMG_H),
    .COL_W(COL_W),
    .ROW_W(ROW_W)
  ) u_pos (
    .CLK    (CLK),
    .RST    (RST),
    .Clear  (clear),
    .Inc    (accept),
    .Col    (col),
    .Row    (row),
    .LastCol(last_col),
    .LastPix(last_pix)
  );

  always_comb begin
    state_d = state_q;
    clear   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.Start) begin
          state_d = FILL;
          clear   = 1'b1;
        end
      end
      // Two full lines must be buffered before any window can be complete.
      FILL: if (accept && last_col && (row == ROW_W'(1))) state_d = RUN;
      RUN:  if (accept && last_pix) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Window is centred one row and one column behind the pixel just shifted in.
  assign wv_d = accept && (row >= ROW_W'(2)) && (col >= COL_W'(2));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      wv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      wv_q    <= wv_d;
    end
  end

  assign bus.PixelReady  = ready;
  assign bus.LineEnable  = accept;
  assign bus.Col         = col;
  assign bus.Row         = row;
  assign bus.WindowValid = wv_q;
  assign bus.FrameDone   = (state_q == DONE);
  assign bus.Busy        = (state_q != IDLE);
  assign bus.State       = state_q;
endmodule

// File: tb/tb_sobel_window_ctrl.sv
// Randomized bench for sobel_window_ctrl: a 4x3 and a 64x64 instance against a frame-level model.
module tb_sobel_window_ctrl;
  import sobel_pkg::*;

  typedef struct packed {
    logic       ready;
    logic       le;
    logic       busy;
    logic       done;
    logic       wv;
    logic [1:0] st;
    logic [5:0] row;
    logic [5:0] col;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sobel_window_ctrl_if #(.IMG_W(4),  .IMG_H(3))  bus_s ();
  sobel_window_ctrl_if #(.IMG_W(64), .IMG_H(64)) bus_b ();

  sobel_window_ctrl #(.IMG_W(4),  .IMG_H(3))  dut_s (.CLK(clk), .RST(rst), .bus(bus_s));
  sobel_window_ctrl #(.IMG_W(64), .IMG_H(64)) dut_b (.CLK(clk), .RST(rst), .bus(bus_b));

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   sel = 0;
  int   W = 4;
  int   H = 3;
  int   m_phase = 0;  // 0 idle, 1 frame in progress, 2 end-of-frame cycle
  int   m_k = 0;      // pixels accepted so far in this frame
  bit   m_wv = 1'b0;
  int   le_cnt = 0;
  int   wv_cnt = 0;
  int   fd_cnt = 0;

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, want);
    end
  endtask

  // Drive one cycle of stimulus and queue the response the model predicts for it.
  task automatic step(input bit r, input bit s, input bit v);
    exp_t e;
    int   row;
    int   col;
    bit   acc;
    @(posedge clk);
    #1;
    rst = r;
    bus_s.Start      = (sel == 0) ? s : 1'b0;
    bus_s.PixelValid = (sel == 0) ? v : 1'b0;
    bus_b.Start      = (sel == 1) ? s : 1'b0;
    bus_b.PixelValid = (sel == 1) ? v : 1'b0;
    e = '0;
    if (r) begin
      m_phase = 0;
      m_k     = 0;
      m_wv    = 1'b0;
    end else begin
      row    = (m_phase == 1) ? m_k / W : 0;
      col    = (m_phase == 1) ? m_k % W : 0;
      acc    = (m_phase == 1) && v;
      e.ready = (m_phase == 1);
      e.le    = acc;
      e.busy  = (m_phase != 0);
      e.done  = (m_phase == 2);
      e.wv    = m_wv;
      e.st    = (m_phase == 0) ? 2'd0 : (m_phase == 2) ? 2'd3 : (m_k < 2 * W) ? 2'd1 : 2'd2;
      e.row   = 6'(row);
      e.col   = 6'(col);
      m_wv    = acc && (row >= 2) && (col >= 2);
      if (m_phase == 0) begin
        if (s) begin
          m_phase = 1;
          m_k     = 0;
        end
      end else if (m_phase == 1) begin
        if (acc) begin
          m_k++;
          if (m_k == W * H) m_phase = 2;
        end
      end else begin
        m_phase = 0;
      end
    end
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    exp_t g;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (sel == 0) begin
        g = {bus_s.PixelReady, bus_s.LineEnable, bus_s.Busy, bus_s.FrameDone,
             bus_s.WindowValid, bus_s.State, 6'(bus_s.Row), 6'(bus_s.Col)};
      end else begin
        g = {bus_b.PixelReady, bus_b.LineEnable, bus_b.Busy, bus_b.FrameDone,
             bus_b.WindowValid, bus_b.State, 6'(bus_b.Row), 6'(bus_b.Col)};
      end
      chk("PixelReady",  int'(g.ready), int'(e.ready));
      chk("LineEnable",  int'(g.le),    int'(e.le));
      chk("Busy",        int'(g.busy),  int'(e.busy));
      chk("FrameDone",   int'(g.done),  int'(e.done));
      chk("WindowValid", int'(g.wv),    int'(e.wv));
      chk("State",       int'(g.st),    int'(e.st));
      chk("Row",         int'(g.row),   int'(e.row));
      chk("Col",         int'(g.col),   int'(e.col));
      if (g.le)   le_cnt++;
      if (g.wv)   wv_cnt++;
      if (g.done) fd_cnt++;
    end
  end

  task automatic drain_and_clear();
    @(negedge clk);
    #1;
    le_cnt = 0;
    wv_cnt = 0;
    fd_cnt = 0;
  endtask

  task automatic check_counts(input string tag, input int frames);
    @(negedge clk);
    #1;
    chk({tag, "_line_enables"}, le_cnt, frames * W * H);
    chk({tag, "_windows"},      wv_cnt, frames * (W - 2) * (H - 2));
    chk({tag, "_frame_done"},   fd_cnt, frames);
  endtask

  // mode 0: continuous, 1: every other cycle, 2: random ~50%.
  task automatic run_pixels(input int mode, input int stop_k);
    int n = 0;
    bit v;
    while (m_phase == 1 && m_k < stop_k && n < 4 * W * H + 16) begin
      v = (mode == 0) ? 1'b1 : (mode == 1) ? bit'(n % 2 == 0) : bit'($urandom_range(0, 1));
      step(1'b0, 1'b0, v);
      n++;
    end
  endtask

  task automatic full_frame(input int mode);
    step(1'b0, 1'b1, 1'b0);
    run_pixels(mode, W * H);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    bus_s.Start = 1'b0;
    bus_s.PixelValid = 1'b0;
    bus_b.Start = 1'b0;
    bus_b.PixelValid = 1'b0;

    sel = 0; W = 4; H = 3;
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1);

    drain_and_clear();
    full_frame(0);
    check_counts("small_cont", 1);

    drain_and_clear();
    full_frame(1);
    check_counts("small_stall", 1);

    drain_and_clear();
    step(1'b0, 1'b1, 1'b0);
    run_pixels(0, W * H);
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    run_pixels(0, W * H);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check_counts("back_to_back", 2);

    sel = 1; W = 64; H = 64;
    step(1'b0, 1'b0, 1'b0);
    drain_and_clear();
    full_frame(2);
    check_counts("big_random", 1);

    drain_and_clear();
    step(1'b0, 1'b1, 1'b0);
    run_pixels(2, 10 * 64 + 5);
    step(1'b0, 1'b1, 1'b1);
    run_pixels(2, 20 * 64 + 7);
    step(1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    drain_and_clear();
    full_frame(2);
    check_counts("after_abort", 1);

    @(negedge clk);
    #1;
    chk("expect_queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sobel_window_ctrl.md
Name: sobel_window_ctrl

Overview:
- Sequences the two 64-cell line-buffer FIFOs and the 3x3 window registers of the Sobel edge-detection pipeline.
- Accepts a raster-order pixel stream through a valid/ready handshake.
- Drives the FIFO Enable strobe so the buffers shift exactly once per accepted pixel.
- Tracks row/column position and flags when the 3x3 window holds a complete, in-frame neighbourhood.

Parameters:
- IMG_W, 64, pixels per line; equals line-buffer depth.
- IMG_H, 64, lines per frame.
- COL_W, $clog2(IMG_W), column counter width.
- ROW_W, $clog2(IMG_H), row counter width.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- Start  in  1  one-cycle request to begin a frame; honoured only in IDLE.
- PixelValid  in  1  upstream pixel present this cycle.
- PixelReady  out  1  controller can accept a pixel.
- LineEnable  out  1  shift strobe to both line-buffer FIFOs and the window registers.
- Col  out  COL_W  column of the next pixel to be accepted.
- Row  out  ROW_W  row of the next pixel to be accepted.
- WindowValid  out  1  window centred at (Row-1, Col-1) of the last accepted pixel is valid.
- FrameDone  out  1  one-cycle pulse at end of frame.
- Busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, any state): state=IDLE; Col=0, Row=0; WindowValid=0, FrameDone=0, PixelReady=0, Busy=0; LineEnable=0.
- FIFO contents are not reset. The FILL phase masks stale data.
- States: IDLE, FILL, RUN, DONE.
- IDLE -> FILL on Start=1. Counters are cleared on this edge.
- FILL -> RUN on accepting pixel (Row=1, Col=IMG_W-1).
- RUN -> DONE on accepting pixel (Row=IMG_H-1, Col=IMG_W-1).
- DONE -> IDLE unconditionally after one cycle.
- PixelReady=1 in FILL and RUN only; 0 in IDLE and DONE.
- Accept = PixelValid & PixelReady.
- LineEnable = Accept, combinational, same cycle. No shift happens without an accept.
- Stall (PixelValid=0): counters, state and LineEnable all hold. WindowValid deasserts the next cycle.
- Col increments on Accept. At IMG_W-1 it wraps to 0 and Row increments.
- Row wraps to 0 after the last pixel of the frame. Counters read 0 in DONE and IDLE.
- WindowValid is registered, with 1-cycle latency after Accept. It is 1 iff the accepted pixel had Row>=2 and Col>=2.
- Border windows are never flagged: first two rows, and columns 0/1 of each row.
- Per frame, exactly (IMG_H-2)*(IMG_W-2) WindowValid pulses occur.
- FrameDone=1 during the DONE cycle only.
- Start while Busy is ignored; no restart and no counter clear.
- Start and RST together: reset wins.
- RST mid-frame: abort immediately to IDLE. Partial frame is discarded; the next Start begins at (0,0).
- PixelValid in IDLE or DONE is not accepted and leaves no side effects.

Decomposition:
- Package sobel_pkg holds:
  - state enum (IDLE=2'd0, FILL=2'd1, RUN=2'd2, DONE=2'd3);
  - IMG_W/IMG_H defaults;
  - PIX_W=8 pixel width shared with the FIFO datapath.
- Sub-module raster_pos_cnt(CLK, RST, Clear, Inc -> Col, Row, LastCol, LastPix) is natural.
  - It holds the wrap logic.
  - The controller instantiates it once and keeps the FSM plus the WindowValid register.

Test Plan:
- Reset/idle: assert RST for 2 cycles, drive PixelValid=1 with no Start.
  - Required: PixelReady=0, LineEnable=0, Row=Col=0, Busy=0 throughout.
- Full frame with IMG_W=4, IMG_H=3, continuous PixelValid after Start.
  - FILL lasts 8 accepts, then RUN.
  - WindowValid high exactly 2 cycles, following accepts of (2,2) and (2,3).
  - FrameDone pulses once, the cycle after the 12th accept; Busy drops the cycle after that.
- Stalls at IMG_W=4, IMG_H=3: drop PixelValid every other cycle.
  - LineEnable count = 12; WindowValid count = 2.
  - Counters hold during gaps; state sequence as in the continuous case.
- Default 64x64, random PixelValid (~50%).
  - Exactly 3844 WindowValid pulses and 4096 LineEnable pulses.
  - FrameDone = 1 pulse.
- Start during RUN at (10,5) is ignored: Row/Col continue to (10,6). Then assert RST at (20,7).
  - Required: immediate IDLE, Row=Col=0, PixelReady=0.
  - A new Start runs a full clean frame with a correct WindowValid count.
- Back-to-back frames: Start asserted in the DONE cycle is ignored. Start one cycle later, in IDLE, begins the second frame.
  - Second frame reproduces identical WindowValid timing.
